// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: multi-stage pipeline register for a processor control bundle.
// Each stage holds a bundle and a valid bit. Stages can be held or flushed
// individually. A held stage also freezes every stage upstream of it.
// Every stage is visible on the outputs for hazard and forwarding logic.
// Two saturating counters record stall cycles and bubbles reaching the last stage.
//
// Handshake: an input beat is captured at a rising edge only when
// i_valid=1 and o_ready=1 and i_flush[0]=0 (and i_rstn=1). o_ready is
// combinational and depends only on i_hold. A beat presented while it is
// not captured is dropped, and upstream must present it again. The output
// side has no back-pressure: o_valid marks a real instruction in the last
// stage, and o_ctrl is guaranteed to be NOP_VAL/RST_VAL whenever o_valid=0.
module ctrl_pipe_reg #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = 5'b00010,
    parameter logic [WIDTH-1:0] NOP_VAL = 5'b00010,
    parameter int               CNT_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [WIDTH-1:0]       i_ctrl,
    input  logic                   i_valid,
    input  logic [DEPTH-1:0]       i_hold,
    input  logic [DEPTH-1:0]       i_flush,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_ctrl,
    output logic                   o_valid,
    output logic [DEPTH*WIDTH-1:0] o_stage_ctrl,
    output logic [DEPTH-1:0]       o_stage_valid,
    output logic [CNT_W-1:0]       o_stall_cnt,
    output logic [CNT_W-1:0]       o_bubble_cnt
);

    logic [WIDTH-1:0] stage_ctrl [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] nxt_ctrl   [DEPTH];
    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] hold_eff;
    logic             bubble_evt;

    // Effective hold: a stage is frozen if it or any downstream stage is held
    always_comb begin
        hold_eff = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hold_eff[k] = |(i_hold >> k);
        end
    end

    assign o_ready = ~hold_eff[0];

    // Next-state selection per stage: flush, then hold, then advance
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            nxt_ctrl[k]  = stage_ctrl[k];
            nxt_valid[k] = stage_valid[k];
        end
        if (i_flush[0]) begin
            nxt_ctrl[0]  = NOP_VAL;
            nxt_valid[0] = 1'b0;
        end else if (!hold_eff[0]) begin
            nxt_ctrl[0]  = i_valid ? i_ctrl : NOP_VAL;
            nxt_valid[0] = i_valid;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (i_flush[k]) begin
                nxt_ctrl[k]  = NOP_VAL;
                nxt_valid[k] = 1'b0;
            end else if (!hold_eff[k]) begin
                // Upstream stage is held but this one is free: insert a bubble
                if (i_hold[k-1]) begin
                    nxt_ctrl[k]  = NOP_VAL;
                    nxt_valid[k] = 1'b0;
                end else begin
                    nxt_ctrl[k]  = stage_ctrl[k-1];
                    nxt_valid[k] = stage_valid[k-1];
                end
            end
        end
    end

    // The last stage takes in an empty slot (flush or invalid advance), but not while it is held
    assign bubble_evt = ~nxt_valid[DEPTH-1] & (i_flush[DEPTH-1] | ~hold_eff[DEPTH-1]);

    // Stage registers with synchronous reset overriding hold and flush
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_ctrl[k] <= RST_VAL;
            end
            stage_valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_ctrl[k] <= nxt_ctrl[k];
            end
            stage_valid <= nxt_valid;
        end
    end

    // Saturating stall counter: counts edges where stage 0 refused input
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_stall_cnt <= '0;
        end else if (!o_ready && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

    // Saturating bubble counter: counts empty slots loaded into the last stage
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_bubble_cnt <= '0;
        end else if (bubble_evt && (o_bubble_cnt != '1)) begin
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage_out
        assign o_stage_ctrl[g*WIDTH +: WIDTH] = stage_ctrl[g];
    end

    assign o_stage_valid = stage_valid;
    assign o_ctrl        = stage_ctrl[DEPTH-1];
    assign o_valid       = stage_valid[DEPTH-1];

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed bench for ctrl_pipe_reg (DEPTH=2, CNT_W=4). The stimulus thread
// pushes each bundle that should reach o_ctrl onto exp_q. A monitor pops one
// entry per newly presented valid output. Counters and stage state are
// checked directly against hand-computed values.
module tb_ctrl_pipe_reg;

    localparam int DEPTH = 2;
    localparam int WIDTH = 5;
    localparam int CNT_W = 4;
    localparam logic [WIDTH-1:0] NOP = 5'b00010;

    logic                   i_clk;
    logic                   i_rstn;
    logic [WIDTH-1:0]       i_ctrl;
    logic                   i_valid;
    logic [DEPTH-1:0]       i_hold;
    logic [DEPTH-1:0]       i_flush;
    logic                   o_ready;
    logic [WIDTH-1:0]       o_ctrl;
    logic                   o_valid;
    logic [DEPTH*WIDTH-1:0] o_stage_ctrl;
    logic [DEPTH-1:0]       o_stage_valid;
    logic [CNT_W-1:0]       o_stall_cnt;
    logic [CNT_W-1:0]       o_bubble_cnt;

    logic [WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    ctrl_pipe_reg #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .RST_VAL (5'b00010),
        .NOP_VAL (5'b00010),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_ctrl        (i_ctrl),
        .i_valid       (i_valid),
        .i_hold        (i_hold),
        .i_flush       (i_flush),
        .o_ready       (o_ready),
        .o_ctrl        (o_ctrl),
        .o_valid       (o_valid),
        .o_stage_ctrl  (o_stage_ctrl),
        .o_stage_valid (o_stage_valid),
        .o_stall_cnt   (o_stall_cnt),
        .o_bubble_cnt  (o_bubble_cnt)
    );

    // Clock and reset block
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one edge, then settle away from it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic rstn, input logic [WIDTH-1:0] ctrl, input logic vld,
                         input logic [DEPTH-1:0] hold, input logic [DEPTH-1:0] flush);
        i_rstn  = rstn;
        i_ctrl  = ctrl;
        i_valid = vld;
        i_hold  = hold;
        i_flush = flush;
    endtask

    // Monitor: one pop per new valid beat on o_ctrl (a held last stage repeats its beat)
    initial begin : monitor
        logic held_last;
        logic [WIDTH-1:0] exp_v;
        forever begin
            @(posedge i_clk);
            held_last = i_rstn & i_hold[DEPTH-1] & ~i_flush[DEPTH-1];
            @(negedge i_clk);
            if (o_valid && !held_last) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(o_ctrl), 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("out_ctrl", 32'(o_ctrl), 32'(exp_v));
                end
            end
        end
    end

    initial begin : stimulus
        // Reset for two edges with a busy input
        drive(1'b0, 5'b11111, 1'b1, 2'b00, 2'b00);
        tick(); tick();
        check("rst_ctrl",   32'(o_ctrl), 32'(NOP));
        check("rst_valid",  32'(o_valid), 32'd0);
        check("rst_svalid", 32'(o_stage_valid), 32'd0);
        check("rst_stages", 32'(o_stage_ctrl), 32'({NOP, NOP}));
        check("rst_stall",  32'(o_stall_cnt), 32'd0);
        check("rst_bubble", 32'(o_bubble_cnt), 32'd0);
        check("rst_ready",  32'(o_ready), 32'd1);

        // Stream A, B, C. Edge 1 moves an empty slot into stage 1, so that is one bubble.
        drive(1'b1, 5'b10001, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b10001);
        tick();
        drive(1'b1, 5'b01100, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b01100);
        tick();
        check("a_out", 32'(o_ctrl), 32'h11);
        check("a_bubble", 32'(o_bubble_cnt), 32'd1);
        drive(1'b1, 5'b00111, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b00111);
        tick();
        check("b_out", 32'(o_ctrl), 32'h0C);

        // Last-stage hold: both stages freeze
        drive(1'b1, 5'b00000, 1'b0, 2'b10, 2'b00);
        #1;
        check("hold1_ready", 32'(o_ready), 32'd0);
        tick();
        check("hold1_out",   32'(o_ctrl), 32'h0C);
        check("hold1_s0",    32'(o_stage_ctrl[4:0]), 32'h07);
        check("hold1_stall", 32'(o_stall_cnt), 32'd1);
        check("hold1_bub",   32'(o_bubble_cnt), 32'd1);

        // Stage-0 hold: a bubble is inserted into stage 1
        drive(1'b1, 5'b00000, 1'b0, 2'b01, 2'b00);
        tick();
        check("hold0_out",   32'(o_ctrl), 32'(NOP));
        check("hold0_valid", 32'(o_valid), 32'd0);
        check("hold0_s0",    32'(o_stage_ctrl[4:0]), 32'h07);
        check("hold0_bub",   32'(o_bubble_cnt), 32'd2);
        check("hold0_stall", 32'(o_stall_cnt), 32'd2);
        drive(1'b1, 5'b00000, 1'b0, 2'b00, 2'b00);
        tick();
        check("c_out", 32'(o_ctrl), 32'h07);
        check("c_bub", 32'(o_bubble_cnt), 32'd2);

        // Load D, E. Edge 7 carries an empty stage 0 into stage 1, so that is one bubble.
        drive(1'b1, 5'b11000, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b11000);
        tick();
        drive(1'b1, 5'b00101, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b00101);
        tick();
        check("d_out", 32'(o_ctrl), 32'h18);

        // Flush beats hold on the last stage
        drive(1'b1, 5'b00000, 1'b0, 2'b10, 2'b10);
        tick();
        check("fh_out",    32'(o_ctrl), 32'(NOP));
        check("fh_valid",  32'(o_valid), 32'd0);
        check("fh_s0",     32'(o_stage_ctrl[4:0]), 32'h05);
        check("fh_s0v",    32'(o_stage_valid[0]), 32'd1);
        check("fh_stall",  32'(o_stall_cnt), 32'd3);
        check("fh_bubble", 32'(o_bubble_cnt), 32'd4);
        drive(1'b1, 5'b00000, 1'b0, 2'b00, 2'b00);
        tick();
        check("e_out", 32'(o_ctrl), 32'h05);

        // Flushing stage 0 drops the presented input
        drive(1'b1, 5'b11110, 1'b1, 2'b00, 2'b01);
        tick();
        check("f0_svalid", 32'(o_stage_valid), 32'd0);
        check("f0_s0",     32'(o_stage_ctrl[4:0]), 32'(NOP));
        check("f0_bubble", 32'(o_bubble_cnt), 32'd5);

        // Reset mid-operation with both stages valid and held
        drive(1'b1, 5'b10100, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b10100);
        tick();
        drive(1'b1, 5'b01010, 1'b1, 2'b00, 2'b00);
        tick();
        check("pre_rst_svalid", 32'(o_stage_valid), 32'd3);
        drive(1'b0, 5'b00000, 1'b0, 2'b11, 2'b00);
        tick();
        check("mrst_stages", 32'(o_stage_ctrl), 32'({NOP, NOP}));
        check("mrst_svalid", 32'(o_stage_valid), 32'd0);
        check("mrst_stall",  32'(o_stall_cnt), 32'd0);
        check("mrst_bubble", 32'(o_bubble_cnt), 32'd0);
        drive(1'b1, 5'b11001, 1'b1, 2'b00, 2'b00); exp_q.push_back(5'b11001);
        tick();
        check("resume_s0v", 32'(o_stage_valid), 32'd1);
        check("resume_bub", 32'(o_bubble_cnt), 32'd1);
        drive(1'b1, 5'b00000, 1'b0, 2'b00, 2'b00);
        tick();
        check("j_out", 32'(o_ctrl), 32'h19);

        // Saturation: 20 stage-0 hold cycles also bubble stage 1 every edge
        drive(1'b1, 5'b00000, 1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall",  32'(o_stall_cnt), 32'hF);
        check("sat_bubble", 32'(o_bubble_cnt), 32'hF);
        drive(1'b1, 5'b00000, 1'b0, 2'b00, 2'b10);
        tick();
        check("sat_bub_flush", 32'(o_bubble_cnt), 32'hF);
        check("sat_stall_hold", 32'(o_stall_cnt), 32'hF);

        drive(1'b1, 5'b00000, 1'b0, 2'b00, 2'b00);
        tick(); tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
